// File: rtl/bpsk_pkg.sv
// bpsk_pkg: shared types and constants for the BPSK receive path.
// ADC frame layout, capture FSM states and the sample type.
package bpsk_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int LEAD_BITS   = 4;
  localparam int SAMPLE_BITS = 12;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    QUIET
  } adc_state_t;

  typedef logic [SAMPLE_BITS-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO with occupancy output.
// Ports: push/push_data/push_ok in, pop_ready/head/valid out, level.
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   push_ok,
  input  logic                   pop_ready,
  output logic [WIDTH-1:0]       head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic             wr;

  assign valid   = (level != '0);
  assign pop     = valid && pop_ready;
  // a full FIFO still takes the sample when the head leaves this cycle
  assign push_ok = (level != FULL) || pop;
  assign wr      = push && push_ok;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: serial ADC frame sequencer feeding a sample FIFO.
// Ports: sysclk, reset(n), enable, cs/sclk/sdo, sample stream, status.
module adc_spi_capture
  import bpsk_pkg::*;
#(
  parameter int CLK_DIV       = 1,
  parameter int SAMPLE_PERIOD = 250,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        enable,
  output logic                        cs,
  output logic                        sclk,
  input  logic                        sdo,
  output logic [SAMPLE_BITS-1:0]      sample_tdata,
  output logic                        sample_tvalid,
  input  logic                        sample_tready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  overflow_cnt,
  output logic                        format_err
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be >= 1");
  end
  if (SAMPLE_PERIOD < 36 * CLK_DIV) begin : g_bad_period
    $error("SAMPLE_PERIOD too short for one frame");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int CW = $clog2(2 * CLK_DIV) + 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] D_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] Q_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS - 1);

  adc_state_t            state, state_d;
  logic [PW-1:0]         per_cnt;
  logic [CW-1:0]         cnt, cnt_d;
  logic [BW-1:0]         bit_idx, bit_d;
  logic                  cs_d, sclk_d;
  logic [FRAME_BITS-1:0] shreg;
  logic                  tick, cap, push, push_ok;
  sample_t               push_data;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)                per_cnt <= '0;
    else if (!enable)          per_cnt <= '0;
    else if (per_cnt == P_LAST) per_cnt <= '0;
    else                       per_cnt <= per_cnt + PW'(1);
  end

  assign tick = enable && (per_cnt == '0);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    cs_d    = cs;
    sclk_d  = sclk;
    cap     = 1'b0;
    push    = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick) begin
          state_d = SETUP;
          cnt_d   = '0;
          cs_d    = 1'b0;
          sclk_d  = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == D_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt != D_LAST) begin
          cnt_d = cnt + CW'(1);
        end else begin
          cnt_d = '0;
          if (!sclk) begin
            sclk_d = 1'b1;
            cap    = 1'b1;
          end else if (bit_idx == B_LAST) begin
            state_d = HOLD;
            push    = 1'b1;
          end else begin
            bit_d  = bit_idx + BW'(1);
            sclk_d = 1'b0;
          end
        end
      end
      HOLD: begin
        if (cnt == D_LAST) begin
          state_d = QUIET;
          cnt_d   = '0;
          cs_d    = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      QUIET: begin
        if (cnt == Q_LAST) begin
          cnt_d = '0;
          // a tick landing on the last quiet cycle starts the next frame
          if (tick) begin
            state_d = SETUP;
            cs_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      cs      <= 1'b1;
      sclk    <= 1'b1;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      cs      <= cs_d;
      sclk    <= sclk_d;
      if (cap) shreg <= {shreg[FRAME_BITS-2:0], sdo};
    end
  end

  assign push_data = shreg[SAMPLE_BITS-1:0];

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      overflow_cnt <= '0;
      format_err   <= 1'b0;
    end else begin
      if (push && !push_ok && overflow_cnt != 8'hFF)
        overflow_cnt <= overflow_cnt + 8'd1;
      if (push && |shreg[FRAME_BITS-1 -: LEAD_BITS])
        format_err <= 1'b1;
    end
  end

  sample_fifo #(
    .WIDTH(SAMPLE_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (sysclk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_data),
    .push_ok   (push_ok),
    .pop_ready (sample_tready),
    .head      (sample_tdata),
    .valid     (sample_tvalid),
    .level     (fifo_level)
  );

endmodule
